spi_in: RTL
===========

// Module: spi_in
// PURPOSE
// - SPI receiver; the peer of the board's 16-bit SPI transmitter (sclk idles high, MSB first,
//   data driven on sclk fall, sampled on sclk rise), with an added active-low frame select.
// - Oversamples the external sclk/cs_n/din on the system clock and deserialises WIDTH-bit words.
// - Outputs each word with a 1-cycle valid strobe toward the ADC/DDS control logic. No sclk clock domain.
// PARAMETERS
// - WIDTH    16   bits per word; counter width = $clog2(WIDTH)
// - TIMEOUT  255  clk cycles without an sclk rise before a frame aborts (SPI_RX_TIMEOUT_EN only)
// PORTS
// - clk         in   1      system clock; sole clock
// - rst         in   1      synchronous, active-high reset
// - sclk_in     in   1      external SPI clock, asynchronous, idle high
// - cs_n_in     in   1      external frame select, asynchronous, active low
// - din         in   1      external serial data, asynchronous
// - data_out    out  WIDTH  last completed word; MSB = first bit received
// - data_valid  out  1      1-cycle pulse: data_out updated this cycle
// - frame_err   out  1      1-cycle pulse: frame ended or aborted with a partial word
// - busy        out  1      high while in SHIFT
// BEHAVIOUR
// - Sync: 3-stage shift register per input (meta, s1, s2); on rst: sclk=1, cs_n=1, din=0.
// - rise = s1_sclk & ~s2_sclk; cs_fall = ~s1_cs & s2_cs; cs_rise = s1_cs & ~s2_cs (combinational).
// - Sampled din = s1_din, aligned with rise. Requirement: clk >= 8x sclk frequency.
// - Reset values: data_out=0, data_valid=0, frame_err=0, busy=0, bit_cnt=0, state=IDLE.
// - FSM states: IDLE, SHIFT.
// - IDLE: enter SHIFT only on cs_fall. If cs_n is already low at reset release, the block waits
//   for cs_n to go high and then low again, so it never joins a frame mid-word. Edges on sclk are ignored.
// - SHIFT, on rise: shreg <= {shreg[WIDTH-2:0], s1_din}; bit_cnt++.
// - SHIFT, on the rise with bit_cnt==WIDTH-1: register data_out <= {shreg[WIDTH-2:0], s1_din},
//   pulse data_valid, set bit_cnt=0, stay in SHIFT (back-to-back words in one frame allowed).
// - SHIFT, on cs_rise: go to IDLE.
//   - bit_cnt!=0: partial word discarded; frame_err pulses; data_out unchanged.
//   - bit_cnt==0: clean end, no pulse.
// - rise and cs_rise in the same cycle: cs_rise wins; the bit is dropped and the partial-word rule applies.
// - Latency: pin sclk rise -> data_valid <= 3 clk edges (meta, s1, register).
// - data_valid and frame_err are never high in the same cycle.
// - rst mid-frame: all state cleared next edge; partial word lost; no pulses.
// - busy = (state==SHIFT), registered.
// CONFIGURATION
// - SPI_RX_TIMEOUT_EN defined:
//   - idle counter cleared on every rise and on cs_fall; increments in SHIFT otherwise.
//   - on reaching TIMEOUT: frame_err pulses (even when bit_cnt==0), go to IDLE, require a new cs_fall.
// - SPI_RX_TIMEOUT_EN undefined: no counter; SHIFT waits indefinitely for sclk or cs_rise.
// TESTING
// - Frame cs low, 16 bits 0xA5C3 MSB first at sclk = clk/54, cs high
//   -> one data_valid, data_out=0xA5C3, no frame_err.
// - One frame carrying 0x1234 then 0xFFFF back-to-back
//   -> two data_valid pulses in order; data_out reads 0x1234, then 0xFFFF.
// - cs high after 9 bits -> frame_err pulse, no data_valid, data_out keeps its prior value.
// - Hold cs_n low through reset release, send 16 bits -> no data_valid.
//   Then cs high/low and send 0x0001 -> data_out=0x0001.
// - rst pulse after 8 bits, then a new full frame of 0x8001 -> only 0x8001 reported.
// - SPI_RX_TIMEOUT_EN, TIMEOUT=255: stop sclk after 5 bits with cs low
//   -> frame_err at cycle 255 after the last rise, busy=0.
//   Without the macro, the same stimulus leaves busy=1 and produces no pulse.

Source files
------------

// File: rtl/spi_in.sv
// spi_in -- oversampled SPI receiver (mode: sclk idles high, MSB first,
// data sampled on sclk rise) with an active-low frame select.
//
// All three external pins are brought into the clk domain through a
// 3-stage shift register (meta, s1, s2); edges are detected between s1 and
// s2, and din is taken from s1 so it lines up with the detected sclk rise.
// Requires clk >= 8x sclk.
//
// Optional feature macro: SPI_RX_TIMEOUT_EN
//   defined   -> a frame with no sclk rise for TIMEOUT clk cycles aborts
//                with a frame_err pulse and the block waits for a new cs fall.
//   undefined -> SHIFT waits indefinitely for sclk or the end of the frame.
//
// Ports:
//   clk        system clock (sole clock)
//   rst        synchronous active-high reset
//   sclk_in    external SPI clock, asynchronous, idle high
//   cs_n_in    external frame select, asynchronous, active low
//   din        external serial data, asynchronous
//   data_out   last completed word, MSB = first bit received
//   data_valid 1-cycle pulse when data_out is updated
//   frame_err  1-cycle pulse when a frame ends or aborts mid-word
//   busy       high while a frame is being received
module spi_in #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk_in,
    input  logic             cs_n_in,
    input  logic             din,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic             sclk_meta, sclk_s1, sclk_s2;
    logic             cs_meta, cs_s1, cs_s2;
    logic             din_meta, din_s1, din_s2;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    // Counts edges since reset release; once it saturates, s2 holds a real
    // pin sample instead of its reset value. A cs fall seen earlier would
    // only mean cs_n was already low at release, i.e. we are mid-frame.
    logic [1:0]       warm;

    logic rise, cs_fall, cs_rise, last_bit;

    assign rise     = sclk_s1 & ~sclk_s2;
    assign cs_fall  = ~cs_s1 & cs_s2 & (warm == 2'd3);
    assign cs_rise  = cs_s1 & ~cs_s2;
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

`ifdef SPI_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    logic          timeout_hit;

    // Fires on the edge at which the counter would reach TIMEOUT.
    assign timeout_hit = (idle_cnt == TW'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta  <= 1'b1; sclk_s1 <= 1'b1; sclk_s2 <= 1'b1;
            cs_meta    <= 1'b1; cs_s1   <= 1'b1; cs_s2   <= 1'b1;
            din_meta   <= 1'b0; din_s1  <= 1'b0; din_s2  <= 1'b0;
            warm       <= '0;
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            sclk_meta <= sclk_in;   sclk_s1 <= sclk_meta; sclk_s2 <= sclk_s1;
            cs_meta   <= cs_n_in;   cs_s1   <= cs_meta;   cs_s2   <= cs_s1;
            din_meta  <= din;       din_s1  <= din_meta;  din_s2  <= din_s1;
            if (warm != 2'd3)
                warm <= warm + 2'd1;

            data_valid <= 1'b0;
            frame_err  <= 1'b0;

`ifdef SPI_RX_TIMEOUT_EN
            if (rise || cs_fall || state == IDLE)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TW'(1);
`endif

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // cs_rise outranks a coincident sclk rise: that bit is dropped.
                    if (cs_rise) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= (bit_cnt != '0);
                        bit_cnt   <= '0;
                    end else if (rise) begin
                        shreg <= {shreg[WIDTH-2:0], din_s1};
                        if (last_bit) begin
                            data_out   <= {shreg[WIDTH-2:0], din_s1};
                            data_valid <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
`ifdef SPI_RX_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
